// File: rtl/lector_pkg.sv
// Shared definitions for the counter-reader block: FSM state encoding and
// the default counter geometry.
package lector_pkg;

  localparam int NUM_CNT       = 4;
  localparam int CNT_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    PEDIR   = 2'd1,
    CAPTURA = 2'd2,
    LISTO   = 2'd3
  } estado_t;

endpackage

// File: rtl/lector_temporizador.sv
// Saturating wait counter for the CAPTURA state. expirado flags the enabled
// cycle on which the count reaches TIMEOUT.
module lector_temporizador #(
  parameter int TIMEOUT = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expirado
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT);
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT - 1);

  logic [W-1:0] cuenta;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (clear) begin
      cuenta <= '0;
    end else if (enable && (cuenta != LIMITE)) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign expirado = enable && (cuenta >= ULTIMO);

endmodule

// File: rtl/lector_contador.sv
// Polls the four per-FIFO word counters into a snapshot on one start command.
// Optional macro LECTOR_SUMA_EN adds a registered sum of the snapshot (suma).
module lector_contador
  import lector_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int IDX_WIDTH = 2,
  parameter int TIMEOUT   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 IDLE,
  input  logic                 valid_contador,
  input  logic [CNT_WIDTH-1:0] contador_out,
  output logic                 req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3,
  output logic                 busy,
  output logic                 done,
  output logic                 error
`ifdef LECTOR_SUMA_EN
  ,
  output logic [CNT_WIDTH+1:0] suma
`endif
);

  estado_t              estado, estado_d;
  logic [IDX_WIDTH-1:0] indice, indice_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic                 error_q, error_d;
  logic                 expirado;

  lector_temporizador #(
    .TIMEOUT (TIMEOUT)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .clear    (estado != CAPTURA),
    .enable   ((estado == CAPTURA) && !valid_contador),
    .expirado (expirado)
  );

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    estado_d = estado;
    indice_d = indice;
    cnt_d    = cnt_q;
    error_d  = error_q;
    unique case (estado)
      ESPERA: begin
        if (start) begin
          estado_d = PEDIR;
          indice_d = '0;
          error_d  = 1'b0;
        end
      end
      PEDIR: begin
        if (IDLE) estado_d = CAPTURA;
      end
      CAPTURA: begin
        // valid_contador is sticky, so the capture point is the fixed
        // one-cycle responder latency, not a valid edge.
        if (valid_contador || expirado) begin
          cnt_d[indice] = valid_contador ? contador_out : '0;
          if (!valid_contador) error_d = 1'b1;
          if (indice == IDX_WIDTH'(NUM_CNT - 1)) begin
            estado_d = LISTO;
          end else begin
            indice_d = indice + 1'b1;
            estado_d = PEDIR;
          end
        end
      end
      LISTO: estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase
  end

  // NOTE: the snapshot array is small and must read zero after reset, so it
  // is reset along with the control state rather than left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado  <= ESPERA;
      indice  <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      estado  <= estado_d;
      indice  <= indice_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req   = (estado == PEDIR) && IDLE;
  assign idx   = indice;
  assign busy  = (estado == PEDIR) || (estado == CAPTURA);
  assign done  = (estado == LISTO);
  assign error = error_q;
  assign cnt0  = cnt_q[0];
  assign cnt1  = cnt_q[1];
  assign cnt2  = cnt_q[2];
  assign cnt3  = cnt_q[3];

`ifdef LECTOR_SUMA_EN
  logic [CNT_WIDTH+1:0] suma_d;

  // Summed from the next-state snapshot so the result is ready while done=1.
  always_comb begin
    suma_d = '0;
    for (int i = 0; i < NUM_CNT; i++) suma_d = suma_d + (CNT_WIDTH+2)'(cnt_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      suma <= '0;
    end else if (estado_d == LISTO) begin
      suma <= suma_d;
    end
  end
`endif

endmodule

// File: tb/tb_lector_contador.sv
// Self-checking bench for lector_contador with a behavioural responder and a
// timeline model of each read sequence.
module tb_lector_contador;

  localparam int CW = 5;
  localparam int TO = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          IDLE;
  logic          valid_contador;
  logic [CW-1:0] contador_out;
  logic          req;
  logic [1:0]    idx;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          busy;
  logic          done;
  logic          error;
`ifdef LECTOR_SUMA_EN
  logic [CW+1:0] suma;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lector_contador dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .IDLE           (IDLE),
    .valid_contador (valid_contador),
    .contador_out   (contador_out),
    .req            (req),
    .idx            (idx),
    .cnt0           (cnt0),
    .cnt1           (cnt1),
    .cnt2           (cnt2),
    .cnt3           (cnt3),
    .busy           (busy),
    .done           (done),
    .error          (error)
`ifdef LECTOR_SUMA_EN
    ,
    .suma           (suma)
`endif
  );

  // Responder: registers the requested counter one cycle after req; valid is
  // sticky, except while a response for a "missed" index is being served.
  logic [CW-1:0] mem [4];
  logic [3:0]    miss;
  logic          valid_stk, bloqueo;
  logic [CW-1:0] resp_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_stk <= 1'b0;
      bloqueo   <= 1'b0;
      resp_q    <= '0;
    end else if (req) begin
      valid_stk <= 1'b1;
      bloqueo   <= miss[idx];
      resp_q    <= mem[idx];
    end
  end

  assign valid_contador = valid_stk & ~bloqueo;
  assign contador_out   = resp_q;

  logic [CW-1:0] cnt_v [4];
  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = cnt1;
  assign cnt_v[2] = cnt2;
  assign cnt_v[3] = cnt3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One read sequence. idle_lo bit c drops IDLE in cycle c; mm marks indices
  // whose response never becomes valid; start2 re-pulses start (-1 = never).
  task automatic run_seq(input logic [63:0] idle_lo, input logic [3:0] mm, input int start2);
    logic          er  [64];
    logic          eiv [64];
    logic [1:0]    ei  [64];
    logic [CW-1:0] ecnt [4];
    logic [31:0]   esum;
    int            c, dc;
    for (int k = 0; k < 64; k++) begin
      er[k] = 1'b0; eiv[k] = 1'b0; ei[k] = 2'd0;
    end
    // Timeline from the rules: each index waits out IDLE=0 cycles, requests
    // for one cycle, then captures after 1 cycle or TO cycles on a miss.
    c = 1;
    for (int i = 0; i < 4; i++) begin
      while (idle_lo[c] && c < 60) begin
        eiv[c] = 1'b1; ei[c] = 2'(i); c++;
      end
      er[c] = 1'b1; eiv[c] = 1'b1; ei[c] = 2'(i); c++;
      c += mm[i] ? TO : 1;
    end
    dc = c;
    esum = 0;
    for (int i = 0; i < 4; i++) begin
      ecnt[i] = mm[i] ? '0 : mem[i];
      esum += 32'(ecnt[i]);
    end
    miss = mm;

    for (int cy = 0; cy <= dc + 2; cy++) begin
      start = (cy == 0) || (cy == start2);
      IDLE  = !idle_lo[cy];
      #1;
      check($sformatf("req@%0d", cy), 32'(req), 32'(er[cy]));
      if (eiv[cy]) check($sformatf("idx@%0d", cy), 32'(idx), 32'(ei[cy]));
      check($sformatf("done@%0d", cy), 32'(done), 32'(cy == dc));
      check($sformatf("busy@%0d", cy), 32'(busy), 32'(cy >= 1 && cy < dc));
      if (cy == 1) check("error_cleared", 32'(error), 32'd0);
      if (cy == dc) begin
        for (int i = 0; i < 4; i++) check($sformatf("cnt%0d", i), 32'(cnt_v[i]), 32'(ecnt[i]));
        check("error_final", 32'(error), 32'(|mm));
`ifdef LECTOR_SUMA_EN
        check("suma", 32'(suma), esum);
`endif
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    IDLE  = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    IDLE  = 1'b1;
    miss  = 4'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #3;
    check("rst_req",  32'(req),  32'd0);
    check("rst_idx",  32'(idx),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(error), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_cnt%0d", i), 32'(cnt_v[i]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Nominal read of 3/7/0/31.
    mem[0] = 5'd3; mem[1] = 5'd7; mem[2] = 5'd0; mem[3] = 5'd31;
    run_seq(64'h0, 4'b0000, -1);

    // IDLE low in cycles 3-5 while index 1 is pending.
    run_seq(64'h38, 4'b0000, -1);

    // Index 2 never answers; next sequence must clear error.
    run_seq(64'h0, 4'b0100, -1);
    run_seq(64'h0, 4'b0000, -1);

    // Start while busy is ignored.
    run_seq(64'h0, 4'b0000, 4);

    // Async reset between edges in cycle 6 of a sequence.
    mem[0] = 5'd9; mem[1] = 5'd12;
    start = 1'b1;
    for (int cy = 0; cy < 6; cy++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req",  32'(req),  32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx",  32'(idx),  32'd0);
    check("mid_rst_err",  32'(error), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("mid_rst_cnt%0d", i), 32'(cnt_v[i]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_seq(64'h0, 4'b0000, -1);

    // All counters at maximum.
    for (int i = 0; i < 4; i++) mem[i] = 5'd31;
    run_seq(64'h0, 4'b0000, -1);

    // Randomised sequences.
    for (int r = 0; r < 6; r++) begin
      logic [63:0] il;
      logic [3:0]  mm;
      il = '0;
      mm = '0;
      for (int i = 0; i < 4; i++) begin
        mem[i] = CW'($urandom);
        mm[i]  = ($urandom_range(0, 3) == 0);
      end
      for (int b = 1; b <= 16; b++) il[b] = ($urandom_range(0, 3) == 0);
      run_seq(il, mm, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
